// File: rtl/cmult_twiddle_pipe_if.sv
// ============================================================================
// Module      : cmult_twiddle_pipe_if
// Description : Input/output handshake and saturation-counter bundle for
//               the twiddle complex multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cmult_twiddle_pipe_if #(
    parameter int DATA_W = 17,
    parameter int COEF_W = 8,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_re;
    logic [DATA_W-1:0] in_im;
    logic [COEF_W-1:0] tw_re;
    logic [COEF_W-1:0] tw_im;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_re;
    logic [DATA_W-1:0] out_im;
    logic              out_sat;
    logic              sat_clr;
    logic [CNT_W-1:0]  sat_cnt;

    modport master (
        output in_valid, in_re, in_im, tw_re, tw_im, out_ready, sat_clr,
        input  in_ready, out_valid, out_re, out_im, out_sat, sat_cnt
    );

    modport slave (
        input  in_valid, in_re, in_im, tw_re, tw_im, out_ready, sat_clr,
        output in_ready, out_valid, out_re, out_im, out_sat, sat_cnt
    );
endinterface

`default_nettype wire

// File: rtl/cmult_twiddle_pipe.sv
// ============================================================================
// Module      : cmult_twiddle_pipe
// Description : 4-stage two's complement complex multiplier (data x twiddle)
//               with scaling, saturation, full-pipeline stall and a sticky
//               saturation counter. Define CMULT_ROUND_NEAREST_EN for
//               round-half-up instead of floor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmult_twiddle_pipe #(
    parameter int DATA_W = 17,
    parameter int COEF_W = 8,
    parameter int FRAC_W = 7,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cmult_twiddle_pipe_if.slave  bus
);

    localparam int c_PW = DATA_W + COEF_W;
    localparam int c_SW = c_PW + 1;
    localparam logic signed [c_SW-1:0] c_MAX = {{(c_SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [c_SW-1:0] c_MIN = {{(c_SW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]       c_CNT_MAX = {CNT_W{1'b1}};

    logic                     w_stall;
    logic                     r_s1_valid, r_s2_valid, r_s3_valid, r_s4_valid;
    logic signed [DATA_W-1:0] r_s1_re, r_s1_im;
    logic signed [COEF_W-1:0] r_s1_wr, r_s1_wi;
    logic signed [c_PW-1:0]   w_ar, w_ai, w_wr, w_wi;
    logic signed [c_PW-1:0]   r_p_rr, r_p_ii, r_p_ri, r_p_ir;
    logic signed [c_SW-1:0]   r_s3_re, r_s3_im;
    logic signed [c_SW-1:0]   w_rnd_re, w_rnd_im, w_sh_re, w_sh_im;
    logic [DATA_W-1:0]        w_q_re, w_q_im;
    logic                     w_sat_re, w_sat_im;
    logic [DATA_W-1:0]        r_out_re, r_out_im;
    logic                     r_out_sat;
    logic [CNT_W-1:0]         r_sat_cnt;

    // Any result waiting downstream freezes the entire pipeline
    assign w_stall      = r_s4_valid & ~bus.out_ready;
    assign bus.in_ready = ~w_stall;

    assign w_ar = {{COEF_W{r_s1_re[DATA_W-1]}}, r_s1_re};
    assign w_ai = {{COEF_W{r_s1_im[DATA_W-1]}}, r_s1_im};
    assign w_wr = {{DATA_W{r_s1_wr[COEF_W-1]}}, r_s1_wr};
    assign w_wi = {{DATA_W{r_s1_wi[COEF_W-1]}}, r_s1_wi};

`ifdef CMULT_ROUND_NEAREST_EN
    localparam logic [c_SW-1:0] c_HALF = {{(c_SW-1){1'b0}}, 1'b1} << (FRAC_W-1);
    assign w_rnd_re = r_s3_re + c_HALF;
    assign w_rnd_im = r_s3_im + c_HALF;
`else
    assign w_rnd_re = r_s3_re;
    assign w_rnd_im = r_s3_im;
`endif

    assign w_sh_re = w_rnd_re >>> FRAC_W;
    assign w_sh_im = w_rnd_im >>> FRAC_W;

    // Returns {saturated, clamped value}
    function automatic logic [DATA_W:0] clamp(input logic signed [c_SW-1:0] v);
        if (v > c_MAX)
            clamp = {1'b1, c_MAX[DATA_W-1:0]};
        else if (v < c_MIN)
            clamp = {1'b1, c_MIN[DATA_W-1:0]};
        else
            clamp = {1'b0, v[DATA_W-1:0]};
    endfunction

    assign {w_sat_re, w_q_re} = clamp(w_sh_re);
    assign {w_sat_im, w_q_im} = clamp(w_sh_im);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
            r_s4_valid <= 1'b0;
            r_s1_re    <= '0;
            r_s1_im    <= '0;
            r_s1_wr    <= '0;
            r_s1_wi    <= '0;
            r_p_rr     <= '0;
            r_p_ii     <= '0;
            r_p_ri     <= '0;
            r_p_ir     <= '0;
            r_s3_re    <= '0;
            r_s3_im    <= '0;
            r_out_re   <= '0;
            r_out_im   <= '0;
            r_out_sat  <= 1'b0;
        end else if (!w_stall) begin
            r_s1_valid <= bus.in_valid;
            r_s1_re    <= bus.in_re;
            r_s1_im    <= bus.in_im;
            r_s1_wr    <= bus.tw_re;
            r_s1_wi    <= bus.tw_im;

            r_s2_valid <= r_s1_valid;
            r_p_rr     <= w_ar * w_wr;
            r_p_ii     <= w_ai * w_wi;
            r_p_ri     <= w_ar * w_wi;
            r_p_ir     <= w_ai * w_wr;

            // One guard bit makes the sums overflow-free
            r_s3_valid <= r_s2_valid;
            r_s3_re    <= {r_p_rr[c_PW-1], r_p_rr} - {r_p_ii[c_PW-1], r_p_ii};
            r_s3_im    <= {r_p_ri[c_PW-1], r_p_ri} + {r_p_ir[c_PW-1], r_p_ir};

            r_s4_valid <= r_s3_valid;
            r_out_re   <= w_q_re;
            r_out_im   <= w_q_im;
            r_out_sat  <= w_sat_re | w_sat_im;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_sat_cnt <= '0;
        else if (bus.sat_clr)
            r_sat_cnt <= '0;
        else if (r_s4_valid && bus.out_ready && r_out_sat && (r_sat_cnt != c_CNT_MAX))
            r_sat_cnt <= r_sat_cnt + CNT_W'(1);
    end

    assign bus.out_valid = r_s4_valid;
    assign bus.out_re    = r_out_re;
    assign bus.out_im    = r_out_im;
    assign bus.out_sat   = r_out_sat;
    assign bus.sat_cnt   = r_sat_cnt;

endmodule

`default_nettype wire

// File: tb/tb_cmult_twiddle_pipe.sv
// ============================================================================
// Module      : tb_cmult_twiddle_pipe
// Description : Self-checking bench: directed scenarios plus random traffic
//               against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cmult_twiddle_pipe;

    localparam int DW    = 17;
    localparam int CW    = 8;
    localparam int FW    = 7;
    localparam int CNTW  = 4;
    localparam int MAXV  = 65535;
    localparam int MINV  = -65536;
    localparam int NRAND = 10000;

    typedef struct {
        int re;
        int im;
        bit sat;
    } res_t;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    res_t exp_q[$];

    cmult_twiddle_pipe_if #(.DATA_W(DW), .COEF_W(CW), .CNT_W(CNTW)) bus ();

    cmult_twiddle_pipe #(.DATA_W(DW), .COEF_W(CW), .FRAC_W(FW), .CNT_W(CNTW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Exact real-valued product divided by 2^FW, floored (or rounded half up), then clamped
    function automatic int scale(input longint s, output bit sat);
        longint d;
        longint q;
        d = longint'(1) << FW;
`ifdef CMULT_ROUND_NEAREST_EN
        s = s + d / 2;
`endif
        q = s / d;
        if ((s % d) != 0 && s < 0) q = q - 1;
        sat = 1'b0;
        if (q > MAXV) begin q = MAXV; sat = 1'b1; end
        if (q < MINV) begin q = MINV; sat = 1'b1; end
        return int'(q);
    endfunction

    function automatic res_t model(input int ar, input int ai, input int wr, input int wi);
        res_t r;
        bit   s_re, s_im;
        r.re  = scale(longint'(ar) * wr - longint'(ai) * wi, s_re);
        r.im  = scale(longint'(ar) * wi + longint'(ai) * wr, s_im);
        r.sat = s_re | s_im;
        return r;
    endfunction

    task automatic drive_in(input int ar, input int ai, input int wr, input int wi);
        bus.in_re = DW'(ar);
        bus.in_im = DW'(ai);
        bus.tw_re = CW'(wr);
        bus.tw_im = CW'(wi);
    endtask

    // One sample into an idle pipe; returns the result and cycles until out_valid
    task automatic send_one(input int ar, input int ai, input int wr, input int wi, input bit clr,
                            output int ore, output int oim, output bit osat, output int lat);
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        drive_in(ar, ai, wr, wi);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 16) begin
            @(negedge clk);
            lat++;
        end
        ore  = $signed(bus.out_re);
        oim  = $signed(bus.out_im);
        osat = bus.out_sat;
        bus.sat_clr = clr;
        @(negedge clk);
        bus.sat_clr = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.sat_clr = 1'b0;
        drive_in(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        total++;
        if ({bus.out_valid, bus.out_sat, bus.out_re, bus.out_im} !== '0)
            $display("FAIL reset_outputs: got v=%b s=%b re=%0d im=%0d want all 0",
                     bus.out_valid, bus.out_sat, bus.out_re, bus.out_im);
        total++;
        if (bus.sat_cnt !== '0) begin
            bad++;
            $display("FAIL reset_sat_cnt: got %0d want 0", bus.sat_cnt);
        end
        if ({bus.out_valid, bus.out_sat, bus.out_re, bus.out_im} !== '0) bad++;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_scaling;
        int re, im, lat;
        bit sat;
        send_one(1000, 0, 64, 0, 1'b0, re, im, sat, lat);
        total++;
        if (lat !== 4) begin bad++; $display("FAIL scale_latency: got %0d want 4", lat); end
        total++;
        if (re !== 500 || im !== 0 || sat !== 1'b0) begin
            bad++;
            $display("FAIL scale_half: got re=%0d im=%0d sat=%b want 500/0/0", re, im, sat);
        end
        send_one(100, -200, 0, 127, 1'b0, re, im, sat, lat);
        total++;
        if (re !== 198 || im !== 99 || sat !== 1'b0) begin
            bad++;
            $display("FAIL scale_j: got re=%0d im=%0d sat=%b want 198/99/0", re, im, sat);
        end
    endtask

    task automatic test_rounding;
        int re, im, lat, want_p, want_n;
        bit sat;
`ifdef CMULT_ROUND_NEAREST_EN
        want_p = 2;
        want_n = -1;
`else
        want_p = 1;
        want_n = -2;
`endif
        send_one(3, 0, 64, 0, 1'b0, re, im, sat, lat);
        total++;
        if (re !== want_p || im !== 0) begin
            bad++;
            $display("FAIL round_pos: got re=%0d im=%0d want %0d/0", re, im, want_p);
        end
        send_one(-3, 0, 64, 0, 1'b0, re, im, sat, lat);
        total++;
        if (re !== want_n || im !== 0) begin
            bad++;
            $display("FAIL round_neg: got re=%0d im=%0d want %0d/0", re, im, want_n);
        end
    endtask

    task automatic test_saturation;
        int re, im, lat;
        bit sat;
        send_one(-65536, -65536, -128, -128, 1'b0, re, im, sat, lat);
        total++;
        if (re !== 0 || im !== 65535 || sat !== 1'b1) begin
            bad++;
            $display("FAIL sat_value: got re=%0d im=%0d sat=%b want 0/65535/1", re, im, sat);
        end
        total++;
        if (bus.sat_cnt !== CNTW'(1)) begin bad++; $display("FAIL sat_cnt_inc: got %0d want 1", bus.sat_cnt); end
        send_one(-65536, -65536, -128, -128, 1'b1, re, im, sat, lat);
        total++;
        if (sat !== 1'b1) begin bad++; $display("FAIL sat_second: got sat=%b want 1", sat); end
        total++;
        if (bus.sat_cnt !== '0) begin bad++; $display("FAIL sat_clr_priority: got %0d want 0", bus.sat_cnt); end
    endtask

    task automatic test_reset_midstream;
        int re, im, lat, n;
        bit sat, stale;
        send_one(-65536, -65536, -128, -128, 1'b0, re, im, sat, lat);
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            drive_in(1000, 0, 64, 0);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 10) begin @(negedge clk); n++; end
        total++;
        if (bus.out_valid !== 1'b1 || bus.sat_cnt === '0 || $signed(bus.out_re) !== 500) begin
            bad++;
            $display("FAIL rst_pre: got v=%b re=%0d cnt=%0d want 1/500/nonzero",
                     bus.out_valid, $signed(bus.out_re), bus.sat_cnt);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.out_valid, bus.out_sat, bus.out_re, bus.out_im, bus.sat_cnt} !== '0) begin
            bad++;
            $display("FAIL rst_async: got v=%b re=%0d im=%0d cnt=%0d want all 0",
                     bus.out_valid, bus.out_re, bus.out_im, bus.sat_cnt);
        end
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stale = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) stale = 1'b1;
        end
        total++;
        if (stale) begin bad++; $display("FAIL rst_stale: got out_valid=1 after reset want 0"); end
        send_one(1000, 0, 64, 0, 1'b0, re, im, sat, lat);
        total++;
        if (lat !== 4 || re !== 500) begin
            bad++;
            $display("FAIL rst_after: got lat=%0d re=%0d want 4/500", lat, re);
        end
    endtask

    task automatic test_backpressure;
        int   ar[8], ai[8], wr[8], wi[8];
        int   sent, got, cyc, first_out, last_cyc;
        bit   prev_stall, ia, oa;
        logic [DW-1:0] h_re, h_im;
        res_t e;
        for (int k = 0; k < 8; k++) begin
            ar[k] = $signed(DW'($urandom));
            ai[k] = $signed(DW'($urandom));
            wr[k] = $signed(CW'($urandom));
            wi[k] = $signed(CW'($urandom));
        end
        exp_q.delete();
        sent = 0; got = 0; cyc = 0; first_out = -1; last_cyc = -1; prev_stall = 1'b0;
        h_re = '0; h_im = '0;
        while (got < 8 && cyc < 100) begin
            @(negedge clk);
            if (prev_stall) begin
                total++;
                if (bus.out_valid !== 1'b1 || bus.out_re !== h_re || bus.out_im !== h_im) begin
                    bad++;
                    $display("FAIL bp_hold: got v=%b re=%0d im=%0d want 1/%0d/%0d",
                             bus.out_valid, bus.out_re, bus.out_im, h_re, h_im);
                end
            end
            bus.out_ready = (cyc >= 12);
            bus.in_valid  = (sent < 8);
            if (sent < 8) drive_in(ar[sent], ai[sent], wr[sent], wi[sent]);
            #1;
            if (bus.out_valid && first_out < 0) begin
                first_out = cyc;
                total++;
                if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got 1 want 0"); end
            end
            ia = bus.in_valid && bus.in_ready;
            oa = bus.out_valid && bus.out_ready;
            if (oa) begin
                e = exp_q.pop_front();
                total++;
                if ($signed(bus.out_re) !== e.re || $signed(bus.out_im) !== e.im || bus.out_sat !== e.sat) begin
                    bad++;
                    $display("FAIL bp_data[%0d]: got %0d/%0d/%b want %0d/%0d/%b", got,
                             $signed(bus.out_re), $signed(bus.out_im), bus.out_sat, e.re, e.im, e.sat);
                end
                if (got > 0) begin
                    total++;
                    if (cyc !== last_cyc + 1) begin
                        bad++;
                        $display("FAIL bp_gap[%0d]: got cycle %0d want %0d", got, cyc, last_cyc + 1);
                    end
                end
                last_cyc = cyc;
                got++;
            end
            if (ia) begin
                exp_q.push_back(model(ar[sent], ai[sent], wr[sent], wi[sent]));
                sent++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            h_re = bus.out_re;
            h_im = bus.out_im;
            cyc++;
        end
        bus.in_valid = 1'b0;
        total++;
        if (got !== 8 || first_out !== 4) begin
            bad++;
            $display("FAIL bp_count: got %0d results first at %0d want 8 at 4", got, first_out);
        end
    endtask

    task automatic test_random;
        int   sent, got, cyc, mcnt;
        bit   prev_stall, ia, oa, esat;
        logic [DW-1:0] h_re, h_im;
        logic h_sat;
        res_t e;
        exp_q.delete();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.sat_clr = 1'b1;
        @(negedge clk);
        bus.sat_clr = 1'b0;
        sent = 0; got = 0; cyc = 0; mcnt = 0; prev_stall = 1'b0;
        h_re = '0; h_im = '0; h_sat = 1'b0;
        while (got < NRAND && cyc < 60000) begin
            @(negedge clk);
            total++;
            if (bus.sat_cnt !== CNTW'(mcnt)) begin
                bad++;
                $display("FAIL rnd_sat_cnt: cycle %0d got %0d want %0d", cyc, bus.sat_cnt, mcnt);
            end
            if (prev_stall) begin
                total++;
                if (bus.out_valid !== 1'b1 || bus.out_re !== h_re || bus.out_im !== h_im || bus.out_sat !== h_sat) begin
                    bad++;
                    $display("FAIL rnd_hold: cycle %0d got re=%0d im=%0d want %0d/%0d",
                             cyc, bus.out_re, bus.out_im, h_re, h_im);
                end
            end
            bus.out_ready = ($urandom_range(0, 99) < 70);
            bus.sat_clr   = ($urandom_range(0, 63) == 0);
            bus.in_valid  = (sent < NRAND) && ($urandom_range(0, 99) < 75);
            drive_in($signed(DW'($urandom)), $signed(DW'($urandom)),
                     $signed(CW'($urandom)), $signed(CW'($urandom)));
            #1;
            total++;
            if (bus.in_ready !== !(bus.out_valid && !bus.out_ready)) begin
                bad++;
                $display("FAIL rnd_in_ready: cycle %0d got %b want %b", cyc, bus.in_ready,
                         !(bus.out_valid && !bus.out_ready));
            end
            ia = bus.in_valid && bus.in_ready;
            oa = bus.out_valid && bus.out_ready;
            esat = 1'b0;
            if (oa) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rnd_extra: cycle %0d got unexpected output want none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    esat = e.sat;
                    if ($signed(bus.out_re) !== e.re || $signed(bus.out_im) !== e.im || bus.out_sat !== e.sat) begin
                        bad++;
                        $display("FAIL rnd_data[%0d]: got %0d/%0d/%b want %0d/%0d/%b", got,
                                 $signed(bus.out_re), $signed(bus.out_im), bus.out_sat, e.re, e.im, e.sat);
                    end
                end
                got++;
            end
            if (bus.sat_clr) mcnt = 0;
            else if (oa && esat && mcnt < (2 ** CNTW) - 1) mcnt++;
            if (ia) begin
                exp_q.push_back(model($signed(bus.in_re), $signed(bus.in_im),
                                      $signed(bus.tw_re), $signed(bus.tw_im)));
                sent++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            h_re = bus.out_re;
            h_im = bus.out_im;
            h_sat = bus.out_sat;
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.sat_clr = 1'b0;
        total++;
        if (got !== NRAND || exp_q.size() != 0) begin
            bad++;
            $display("FAIL rnd_count: got %0d results (%0d left) want %0d", got, exp_q.size(), NRAND);
        end
        @(negedge clk);
        total++;
        if (bus.sat_cnt !== CNTW'(mcnt)) begin
            bad++;
            $display("FAIL rnd_sat_final: got %0d want %0d", bus.sat_cnt, mcnt);
        end
    endtask

    initial begin
        test_reset();
        test_scaling();
        test_rounding();
        test_saturation();
        test_reset_midstream();
        test_backpressure();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
